// File: rtl/wash_cycle_sequencer_if.sv
// Panel/sensor-to-sequencer bundle: programme commands, sensor readings and
// actuator/status outputs of the wash cycle sequencer.
interface wash_cycle_sequencer_if #(
  parameter int TEMP_W  = 7,
  parameter int LEVEL_W = 10,
  parameter int RC_W    = 2
);
  logic               start;
  logic               stop;
  logic               pause;
  logic               continue_signal;
  logic               door_locked;
  logic               clothes_loaded;
  logic [RC_W-1:0]    rinse_count;
  logic [TEMP_W-1:0]  target_temp;
  logic [LEVEL_W-1:0] target_level;
  logic [TEMP_W-1:0]  temperature_adc_sensor;
  logic [LEVEL_W-1:0] water_level_sensor;
  logic               vibration_sensor;

  logic               door_lock;
  logic               water_valve;
  logic               heater;
  logic               drain_pump;
  logic               motor_en;
  logic               motor_spin;
  logic [3:0]         state_code;
  logic [RC_W-1:0]    rinses_done;
  logic               cycle_complete_led;
  logic               fault;
  logic [1:0]         fault_code;

  // panel/sensor side
  modport master (
    output start, stop, pause, continue_signal, door_locked, clothes_loaded,
           rinse_count, target_temp, target_level, temperature_adc_sensor,
           water_level_sensor, vibration_sensor,
    input  door_lock, water_valve, heater, drain_pump, motor_en, motor_spin,
           state_code, rinses_done, cycle_complete_led, fault, fault_code
  );

  // sequencer side
  modport slave (
    input  start, stop, pause, continue_signal, door_locked, clothes_loaded,
           rinse_count, target_temp, target_level, temperature_adc_sensor,
           water_level_sensor, vibration_sensor,
    output door_lock, water_valve, heater, drain_pump, motor_en, motor_spin,
           state_code, rinses_done, cycle_complete_led, fault, fault_code
  );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Wash programme sequencer: fill, heat, wash, N rinse loops, spin, with
// pause/resume, abort drain, fill/drain timeouts and a spin vibration trip.
//
// state       | meaning
// IDLE        | waiting for start with door locked and clothes loaded
// FILL        | inlet valve open until target level
// HEAT        | heater on until target temperature
// WASH        | drum turning for WASH_TICKS cycles
// DRAIN       | pump on until drum empty
// RINSE_FILL  | inlet valve open for a rinse loop
// RINSE       | drum turning for RINSE_TICKS cycles
// SPIN        | high-speed spin for SPIN_TICKS cycles
// COMPLETE    | one-cycle completion pulse
// PAUSED      | actuators off, phase time and return state held
// ABORT_DRAIN | stop requested, pumping out before IDLE
// FAULT       | timeout or vibration trip, held until stop
module wash_cycle_sequencer #(
  parameter int TEMP_W        = 7,
  parameter int LEVEL_W       = 10,
  parameter int RC_W          = 2,
  parameter int CNT_W         = 16,
  parameter int WASH_TICKS    = 1200,
  parameter int RINSE_TICKS   = 600,
  parameter int SPIN_TICKS    = 900,
  parameter int FILL_TIMEOUT  = 3000,
  parameter int DRAIN_TIMEOUT = 3000,
  parameter int EMPTY_LEVEL   = 10,
  parameter int VIB_LIMIT     = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  wash_cycle_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FILL = 4'd1, S_HEAT = 4'd2, S_WASH = 4'd3,
    S_DRAIN = 4'd4, S_RINSE_FILL = 4'd5, S_RINSE = 4'd6, S_SPIN = 4'd7,
    S_COMPLETE = 4'd8, S_PAUSED = 4'd9, S_ABORT_DRAIN = 4'd10, S_FAULT = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0]   WASH_LAST  = CNT_W'(WASH_TICKS - 1);
  localparam logic [CNT_W-1:0]   RINSE_LAST = CNT_W'(RINSE_TICKS - 1);
  localparam logic [CNT_W-1:0]   SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
  localparam logic [CNT_W-1:0]   FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   VIB_LAST   = CNT_W'(VIB_LIMIT - 1);
  localparam logic [LEVEL_W-1:0] EMPTY_LVL  = LEVEL_W'(EMPTY_LEVEL);

  state_t             state_q, state_d, ret_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, vib_q, vib_d;
  logic [RC_W-1:0]    rc_q, rd_q;
  logic [TEMP_W-1:0]  temp_q;
  logic [LEVEL_W-1:0] lvl_q;
  logic [1:0]         fc_q, fault_kind;
  logic               active, counting, filled, heated, empty;

  assign active   = (state_q >= S_FILL) && (state_q <= S_SPIN);
  assign counting = active || (state_q == S_ABORT_DRAIN);
  assign filled   = bus.water_level_sensor >= lvl_q;
  assign heated   = bus.temperature_adc_sensor >= temp_q;
  assign empty    = bus.water_level_sensor <= EMPTY_LVL;

  // fault detection: phase timeouts with the exit still false, or sustained spin vibration
  always_comb begin
    fault_kind = 2'b00;
    if ((state_q == S_FILL || state_q == S_RINSE_FILL) && !filled && cnt_q == FILL_LAST)
      fault_kind = 2'b01;
    if (state_q == S_HEAT && !heated && cnt_q == FILL_LAST)
      fault_kind = 2'b01;
    if ((state_q == S_DRAIN || state_q == S_ABORT_DRAIN) && !empty && cnt_q == DRAIN_LAST)
      fault_kind = 2'b10;
    if (state_q == S_SPIN && bus.vibration_sensor && vib_q == VIB_LAST)
      fault_kind = 2'b11;
  end

  // next state: stop, then fault, then pause/door, then the programme arcs
  always_comb begin
    state_d = state_q;
    if (bus.stop && state_q == S_FAULT) begin
      state_d = S_IDLE;
    end else if (bus.stop && (active || state_q == S_PAUSED)) begin
      state_d = S_ABORT_DRAIN;
    end else if (fault_kind != 2'b00) begin
      state_d = S_FAULT;
    end else if (active && (bus.pause || !bus.door_locked)) begin
      // entry into any active state needs a locked door, so a low level here means it fell
      state_d = S_PAUSED;
    end else begin
      case (state_q)
        S_IDLE:        if (bus.start && bus.door_locked && bus.clothes_loaded) state_d = S_FILL;
        S_FILL:        if (filled) state_d = S_HEAT;
        S_HEAT:        if (heated) state_d = S_WASH;
        S_WASH:        if (cnt_q == WASH_LAST) state_d = S_DRAIN;
        S_DRAIN:       if (empty) state_d = (rd_q < rc_q) ? S_RINSE_FILL : S_SPIN;
        S_RINSE_FILL:  if (filled) state_d = S_RINSE;
        S_RINSE:       if (cnt_q == RINSE_LAST) state_d = S_DRAIN;
        S_SPIN:        if (cnt_q == SPIN_LAST) state_d = S_COMPLETE;
        S_COMPLETE:    state_d = S_IDLE;
        S_PAUSED:      if (bus.continue_signal && bus.door_locked) state_d = ret_q;
        S_ABORT_DRAIN: if (empty) state_d = S_IDLE;
        S_FAULT:       state_d = S_FAULT;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  // phase counter: the cycle that leads into PAUSED still counts, resume keeps the count
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      if (state_d == S_PAUSED)
        cnt_d = cnt_q + CNT_W'(1);
      else if (state_q == S_PAUSED && state_d != S_ABORT_DRAIN)
        cnt_d = cnt_q;
      else
        cnt_d = '0;
    end else if (counting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    vib_d = (state_q == S_SPIN && bus.vibration_sensor) ? vib_q + CNT_W'(1) : '0;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // counters, programme latches, return state, rinse tally and fault code
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      vib_q  <= '0;
      ret_q  <= S_IDLE;
      rc_q   <= '0;
      temp_q <= '0;
      lvl_q  <= '0;
      rd_q   <= '0;
      fc_q   <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      vib_q <= vib_d;
      if (state_d == S_PAUSED && state_q != S_PAUSED) ret_q <= state_q;
      if (state_q == S_IDLE && state_d == S_FILL) begin
        rc_q   <= bus.rinse_count;
        temp_q <= bus.target_temp;
        lvl_q  <= bus.target_level;
        rd_q   <= '0;
      end
      if (state_q == S_RINSE && state_d == S_DRAIN) rd_q <= rd_q + RC_W'(1);
      if (state_d == S_FAULT && state_q != S_FAULT) fc_q <= fault_kind;
      else if (state_q == S_FAULT && state_d == S_IDLE) fc_q <= 2'b00;
    end
  end

  // actuator and status decode from the state register
  always_comb begin
    bus.door_lock          = (state_q != S_IDLE) && (state_q != S_COMPLETE);
    bus.water_valve        = (state_q == S_FILL) || (state_q == S_RINSE_FILL);
    bus.heater             = (state_q == S_HEAT);
    bus.drain_pump         = (state_q == S_DRAIN) || (state_q == S_ABORT_DRAIN);
    bus.motor_en           = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN);
    bus.motor_spin         = (state_q == S_SPIN);
    bus.state_code         = state_q;
    bus.rinses_done        = rd_q;
    bus.cycle_complete_led = (state_q == S_COMPLETE);
    bus.fault              = (state_q == S_FAULT);
    bus.fault_code         = fc_q;
  end
endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: directed programme scenarios plus random
// panel/sensor traffic, every cycle checked against a behavioural model.
module tb_wash_cycle_sequencer;
  localparam int TEMP_W = 7;
  localparam int LEVEL_W = 10;
  localparam int RC_W = 2;
  localparam int WASH_T = 8;
  localparam int RINSE_T = 4;
  localparam int SPIN_T = 6;
  localparam int FILL_TO = 20;
  localparam int DRAIN_TO = 30;
  localparam int EMPTY = 10;
  localparam int VIB = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wash_cycle_sequencer_if #(.TEMP_W(TEMP_W), .LEVEL_W(LEVEL_W), .RC_W(RC_W)) bus ();

  wash_cycle_sequencer #(
    .TEMP_W(TEMP_W), .LEVEL_W(LEVEL_W), .RC_W(RC_W), .CNT_W(16),
    .WASH_TICKS(WASH_T), .RINSE_TICKS(RINSE_T), .SPIN_TICKS(SPIN_T),
    .FILL_TIMEOUT(FILL_TO), .DRAIN_TIMEOUT(DRAIN_TO),
    .EMPTY_LEVEL(EMPTY), .VIB_LIMIT(VIB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail = 0;

  // behavioural model: state number as listed in the state_code table
  int m_state, m_spent, m_vib, m_ret, m_rc, m_tt, m_tl, m_rd, m_fc;
  bit plant_on;
  int drain_lvl;

  // {door_lock, water_valve, heater, drain_pump, motor_en, motor_spin} per state
  function automatic logic [5:0] act_for(input int s);
    case (s)
      1, 5:    return 6'b110000;
      2:       return 6'b101000;
      3, 6:    return 6'b100010;
      7:       return 6'b100011;
      4, 10:   return 6'b100100;
      9, 11:   return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic bit counts_time(input int s);
    return (s >= 1 && s <= 7) || s == 10;
  endfunction

  task automatic model_step();
    int  ns, lvl, tmp, done_here, vib_run, code;
    bit  active;
    if (!reset) begin
      m_state = 0; m_spent = 0; m_vib = 0; m_ret = 0;
      m_rc = 0; m_tt = 0; m_tl = 0; m_rd = 0; m_fc = 0;
      return;
    end
    lvl = int'(bus.water_level_sensor);
    tmp = int'(bus.temperature_adc_sensor);
    active = (m_state >= 1 && m_state <= 7);
    done_here = m_spent + 1;
    vib_run = (m_state == 7 && bus.vibration_sensor) ? m_vib + 1 : 0;
    code = 0;
    if ((m_state == 1 || m_state == 5) && lvl < m_tl && done_here == FILL_TO) code = 1;
    if (m_state == 2 && tmp < m_tt && done_here == FILL_TO) code = 1;
    if ((m_state == 4 || m_state == 10) && lvl > EMPTY && done_here == DRAIN_TO) code = 2;
    if (m_state == 7 && vib_run == VIB) code = 3;
    ns = m_state;
    if (bus.stop && m_state == 11) begin
      ns = 0; m_fc = 0;
    end else if (bus.stop && (active || m_state == 9)) begin
      ns = 10;
    end else if (code != 0) begin
      ns = 11; m_fc = code;
    end else if (active && (bus.pause || !bus.door_locked)) begin
      ns = 9; m_ret = m_state;
    end else begin
      case (m_state)
        0: if (bus.start && bus.door_locked && bus.clothes_loaded) begin
             ns = 1; m_rc = int'(bus.rinse_count); m_tt = int'(bus.target_temp);
             m_tl = int'(bus.target_level); m_rd = 0;
           end
        1: if (lvl >= m_tl) ns = 2;
        2: if (tmp >= m_tt) ns = 3;
        3: if (done_here == WASH_T) ns = 4;
        4: if (lvl <= EMPTY) ns = (m_rd < m_rc) ? 5 : 7;
        5: if (lvl >= m_tl) ns = 6;
        6: if (done_here == RINSE_T) begin ns = 4; m_rd = m_rd + 1; end
        7: if (done_here == SPIN_T) ns = 8;
        8: ns = 0;
        9: if (bus.continue_signal && bus.door_locked) ns = m_ret;
        10: if (lvl <= EMPTY) ns = 0;
        default: ;
      endcase
    end
    if (ns == m_state) begin
      if (counts_time(m_state)) m_spent = done_here;
    end else if (ns == 9) begin
      m_spent = done_here;
    end else if (!(m_state == 9 && ns != 10)) begin
      m_spent = 0;
    end
    m_vib = vib_run;
    m_state = ns;
  endtask

  task automatic compare_outputs();
    logic [15:0] act, exp;
    act = {bus.state_code, bus.door_lock, bus.water_valve, bus.heater, bus.drain_pump,
           bus.motor_en, bus.motor_spin, bus.rinses_done, bus.cycle_complete_led,
           bus.fault, bus.fault_code};
    exp = {4'(m_state), act_for(m_state), 2'(m_rd), (m_state == 8), (m_state == 11), 2'(m_fc)};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle_compare t=%0t dut=%h model=%h", $time, act, exp);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic plant();
    case (m_state)
      1, 5:  bus.water_level_sensor = LEVEL_W'(m_tl);
      2:     bus.temperature_adc_sensor = TEMP_W'(m_tt);
      4, 10: bus.water_level_sensor = LEVEL_W'(drain_lvl);
      default: ;
    endcase
  endtask

  // one clock: compare on the falling edge, advance the model on the rising edge
  task automatic tick();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step();
    tick();
    if (plant_on) plant();
  endtask

  task automatic wait_model(input string name, input int s, input int bound);
    for (int c = 0; c < bound && m_state != s; c++) step();
    check(name, int'(bus.state_code), s);
  endtask

  task automatic begin_prog(input int rc, input int tl, input int tt);
    bus.rinse_count = RC_W'(rc);
    bus.target_level = LEVEL_W'(tl);
    bus.target_temp = TEMP_W'(tt);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  int  exp_codes[13] = '{1, 2, 3, 4, 5, 6, 4, 5, 6, 4, 7, 8, 0};
  int  exp_lens[12]  = '{1, 1, 8, 1, 1, 4, 1, 1, 4, 1, 6, 1};
  int  codes[16];
  int  lens[16];
  bit  gap_pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_runs, prev, code, leds, w;
    reset = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.continue_signal = 1'b0;
    bus.door_locked = 1'b1; bus.clothes_loaded = 1'b1; bus.rinse_count = '0;
    bus.target_temp = '0; bus.target_level = '0; bus.temperature_adc_sensor = TEMP_W'(20);
    bus.water_level_sensor = '0; bus.vibration_sensor = 1'b0;
    plant_on = 1'b1; drain_lvl = 0;
    @(posedge clk);
    model_step();
    #1;
    reset = 1'b1;
    check("reset_state", int'(bus.state_code), 0);
    check("reset_door_lock", int'(bus.door_lock), 0);
    check("reset_fault_code", int'(bus.fault_code), 0);

    // full programme with two rinses
    begin_prog(2, 300, 40);
    n_runs = 0; prev = -1; leds = 0;
    for (int i = 0; i < 16; i++) begin codes[i] = -1; lens[i] = 0; end
    for (int c = 0; c < 200; c++) begin
      code = int'(bus.state_code);
      if (code == prev) lens[n_runs-1]++;
      else if (n_runs < 16) begin codes[n_runs] = code; lens[n_runs] = 1; n_runs++; end
      prev = code;
      if (bus.cycle_complete_led) leds++;
      if (code == 0) break;
      step();
    end
    check("t1_runs", n_runs, 13);
    for (int i = 0; i < 13; i++) check($sformatf("t1_code[%0d]", i), codes[i], exp_codes[i]);
    for (int i = 0; i < 12; i++) check($sformatf("t1_len[%0d]", i), lens[i], exp_lens[i]);
    check("t1_rinses_done", int'(bus.rinses_done), 2);
    check("t1_model_rinses", m_rd, 2);
    check("t1_led_pulses", leds, 1);

    // zero rinses: drain at level 5 goes straight to spin
    drain_lvl = 5;
    bus.temperature_adc_sensor = TEMP_W'(20);
    begin_prog(0, 300, 40);
    wait_model("t2_reach_drain", 4, 50);
    step();
    check("t2_drain_to_spin", int'(bus.state_code), 7);
    check("t2_rinses_done", int'(bus.rinses_done), 0);
    wait_model("t2_idle", 0, 50);

    // pause after three WASH cycles, ten cycles paused, then resume
    drain_lvl = 0;
    begin_prog(0, 300, 40);
    wait_model("t3_reach_wash", 3, 50);
    step(); step();
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    check("t3_paused", int'(bus.state_code), 9);
    check("t3_motor_off", int'(bus.motor_en), 0);
    check("t3_door_lock", int'(bus.door_lock), 1);
    for (int i = 0; i < 9; i++) step();
    bus.continue_signal = 1'b1;
    step();
    bus.continue_signal = 1'b0;
    w = 0;
    while (bus.state_code == 4'd3 && w < 20) begin w++; step(); end
    check("t3_wash_remaining", w, 5);
    wait_model("t3_idle", 0, 50);

    // fill timeout with level stuck at 100
    plant_on = 1'b0;
    bus.water_level_sensor = LEVEL_W'(100);
    begin_prog(0, 300, 40);
    w = 0;
    while (bus.state_code == 4'd1 && w < 40) begin w++; step(); end
    check("t4_fill_cycles", w, 20);
    check("t4_state", int'(bus.state_code), 11);
    check("t4_fault_code", int'(bus.fault_code), 1);
    check("t4_actuators", int'({bus.water_valve, bus.heater, bus.drain_pump, bus.motor_en, bus.motor_spin}), 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("t4_stop_state", int'(bus.state_code), 0);
    check("t4_stop_code", int'(bus.fault_code), 0);

    // three vibration cycles in spin trip the fault
    plant_on = 1'b1;
    begin_prog(0, 300, 40);
    wait_model("t5_reach_spin", 7, 60);
    bus.vibration_sensor = 1'b1;
    step(); step(); step();
    bus.vibration_sensor = 1'b0;
    check("t5_vib_state", int'(bus.state_code), 11);
    check("t5_vib_code", int'(bus.fault_code), 3);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("t5_stop_state", int'(bus.state_code), 0);

    // same with a one-cycle gap: spin completes
    begin_prog(0, 300, 40);
    wait_model("t5g_reach_spin", 7, 60);
    for (int i = 0; i < 5; i++) begin bus.vibration_sensor = gap_pat[i]; step(); end
    bus.vibration_sensor = 1'b0;
    w = 0;
    while (bus.state_code != 4'd8 && w < 10) begin w++; step(); end
    check("t5g_complete", int'(bus.state_code), 8);
    check("t5g_no_fault", int'(bus.fault_code), 0);
    wait_model("t5g_idle", 0, 10);

    // reset pulse in the second rinse
    begin_prog(2, 300, 40);
    for (int c = 0; c < 100 && !(m_state == 6 && m_rd == 1); c++) step();
    check("t6_in_rinse2", int'(bus.state_code), 6);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("t6_state", int'(bus.state_code), 0);
    check("t6_door_lock", int'(bus.door_lock), 0);
    check("t6_rinses_done", int'(bus.rinses_done), 0);

    // random panel and sensor traffic
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(3) == 0);
      bus.stop = ($urandom_range(59) == 0);
      bus.pause = ($urandom_range(39) == 0);
      bus.continue_signal = ($urandom_range(3) == 0);
      bus.door_locked = ($urandom_range(29) != 0);
      bus.clothes_loaded = ($urandom_range(9) != 0);
      bus.vibration_sensor = ($urandom_range(2) == 0);
      bus.rinse_count = RC_W'($urandom_range(3));
      bus.target_temp = TEMP_W'($urandom_range(60, 30));
      bus.target_level = LEVEL_W'($urandom_range(400, 100));
      reset = ($urandom_range(499) != 0);
      drain_lvl = int'($urandom_range(15));
      plant();
      if ($urandom_range(3) == 0) bus.water_level_sensor = LEVEL_W'($urandom_range(500));
      if ($urandom_range(3) == 0) bus.temperature_adc_sensor = TEMP_W'($urandom_range(80));
      tick();
    end
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
